seq_fixed_point_accumulator: RTL and testbench
==============================================

# seq_fixed_point_accumulator

Packet-oriented signed fixed-point accumulator that sits directly downstream of the combinational fixed-point add/sub stage in the datapath. It takes a stream of signed samples, each tagged add or subtract, and sums them into a register in the output Q-format. On the sample tagged last it presents the result with sticky overflow flags through a valid/ready handshake. Input conversion, saturation and rounding follow the library-wide fixed-point rules, so results match the combinational zoom/add-sub blocks bit-for-bit.

## Interface
- WII, 8: integer bits of input sample, sign included
- WIF, 8: fraction bits of input sample
- WOI, 8: integer bits of accumulator/output, sign included
- WOF, 8: fraction bits of accumulator/output
- ROOF, 1: 1 = saturate on overflow; 0 = two's-complement wrap
- ROUND, 1: 1 = round half toward +inf when dropping fraction bits; 0 = truncate
- CNTW, 16: width of sample counter
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous packet abort
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_data  in  WII+WIF  signed sample
- in_sub  in  1  0 = add sample, 1 = subtract sample
- in_last  in  1  sample closes the packet
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WOI+WOF  accumulated result
- out_upflow  out  1  sticky: some step exceeded the positive range
- out_downflow  out  1  sticky: some step went below the negative range
- out_cnt  out  CNTW  samples in packet (see Configuration)

## Operation
- FSM has two states.
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset (rst=1) sets state=ACCUM, acc=0, flags=0, cnt=0, and all outputs to 0 except in_ready=1.
- Sample conversion: in_data is resized to WOI.WOF.
  - Fraction: rounded per ROUND or truncated.
  - Integer part: sign-extended, or clamped per ROOF. A clamp during conversion sets the matching flag.
- Step arithmetic:
  - The exact sum is formed at width WOI+WOF+2: acc + conv, or acc − conv when in_sub=1.
  - If sum > max: upflow is set. The result is max when ROOF=1, or the low WOI+WOF bits when ROOF=0.
  - If sum < min: downflow is set, with the symmetric result.
- Accepted sample with in_last=0: acc updates, flags OR in, cnt increments, state stays ACCUM.
- Accepted sample with in_last=1: the stepped result, flags and cnt+1 are loaded into the out_* registers. acc, flags and cnt clear. State goes to HOLD.
- HOLD with out_ready=1: out_valid drops next cycle and state returns to ACCUM. out_data and flags hold their last values.
- clr=1: acc, flags and cnt clear, state goes to ACCUM, out_valid goes to 0 (a pending result is discarded), and a sample presented that cycle is dropped.
- Priority: rst > clr > handshakes.
- cnt wraps modulo 2^CNTW.

## Timing
- The result appears one cycle after the accepting edge of the last sample.
- Single-sample packet: out_valid asserts the cycle after acceptance.
- in_ready is a registered function of state, with no combinational path from out_ready.
- Back-to-back packets lose one bubble cycle per packet: the cycle in which HOLD is left has in_ready=0.
- out_data, out_upflow, out_downflow and out_cnt stay stable while out_valid=1 && out_ready=0.

## Configuration
- FIXEDPOINT_ACC_COUNT_EN
  - Defined: sample counter is compiled in and out_cnt reports the packet length.
  - Undefined: counter is removed and out_cnt is tied to 0. All other behaviour is identical.

## Test plan
All scenarios use the default parameters unless stated.
- Add 0x0180 (1.5), add 0x0240 (2.25), subtract 0x0080 (0.5) with last -> out_data=0x0340 (3.25), flags 0/0, out_cnt=3 (0 with macro off).
- ROOF=1: add 0x6400 (100), add 0x6400 with last -> out_data=0x7FFF, upflow=1. Same stimulus with ROOF=0 -> 0xC800, upflow=1.
- WOF=4, ROUND=1: single sample 0x0018 with last -> 0x0002. Same with ROUND=0 -> 0x0001.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_data stable throughout. Then one cycle with out_ready=1 -> in_ready=1 next cycle.
- Assert clr mid-packet after two samples, then send 0x0100 with last -> out_data=0x0100, out_cnt=1.
- Assert rst while in HOLD -> next cycle out_valid=0, in_ready=1, all out_* = 0.

Source files
------------

// File: rtl/seq_fixed_point_accumulator_if.sv
// Handshake bundle for seq_fixed_point_accumulator: the sample stream goes in and the packet result comes out.
interface seq_fixed_point_accumulator_if #(
  parameter int WI   = 16,
  parameter int WO   = 16,
  parameter int CNTW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [WI-1:0]   in_data;
  logic            in_sub;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [WO-1:0]   out_data;
  logic            out_upflow;
  logic            out_downflow;
  logic [CNTW-1:0] out_cnt;

  modport master (
    output in_valid, in_data, in_sub, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_upflow, out_downflow, out_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_data, out_upflow, out_downflow, out_cnt
  );
endinterface

// File: rtl/seq_fixed_point_accumulator.sv
// Packet accumulator for signed fixed-point samples, with sticky over/underflow flags.
// Defining FIXEDPOINT_ACC_COUNT_EN compiles in the per-packet sample counter; otherwise out_cnt is 0.
//
// state | meaning
// ACCUM | samples are accepted and summed into acc
// HOLD  | the packet result is presented and waits for out_ready
module seq_fixed_point_accumulator #(
  parameter int WII  = 8,
  parameter int WIF  = 8,
  parameter int WOI  = 8,
  parameter int WOF  = 8,
  parameter bit ROOF = 1'b1,
  parameter bit ROUND = 1'b1,
  parameter int CNTW = 16
) (
  input logic clk,
  input logic rst,
  input logic clr,
  seq_fixed_point_accumulator_if.slave bus
);
  localparam int WI  = WII + WIF;
  localparam int WO  = WOI + WOF;
  localparam int WS  = WO + 2;
  localparam int WX  = WI + WO + 4;
  localparam int SHL = (WOF >= WIF) ? WOF - WIF : 0;
  localparam int SHR = (WIF > WOF) ? WIF - WOF : 0;

  localparam logic signed [WX-1:0] CMAX = {{(WX-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WX-1:0] CMIN = {{(WX-WO+1){1'b1}}, {(WO-1){1'b0}}};
  localparam logic signed [WS-1:0] SMAX = {3'b000, {(WO-1){1'b1}}};
  localparam logic signed [WS-1:0] SMIN = {3'b111, {(WO-1){1'b0}}};
  // Half of the dropped LSB weight; adding it before the floor shift rounds half toward +inf.
  localparam logic signed [WX-1:0] RND =
    (ROUND && SHR > 0) ? ({{(WX-1){1'b0}}, 1'b1} << SHR) >> 1 : '0;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state;
  logic                 in_ready_q, out_valid_q;
  logic [WO-1:0]        acc_q, out_data_q;
  logic                 up_q, dn_q, out_up_q, out_dn_q;
  logic signed [WX-1:0] ext, scaled;
  logic [WO-1:0]        conv, step;
  logic                 conv_up, conv_dn, step_up, step_dn, up_n, dn_n;
  logic signed [WS-1:0] sum;
  logic                 accept;

  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    ext     = {{(WX-WI){bus.in_data[WI-1]}}, bus.in_data};
    scaled  = ((ext <<< SHL) + RND) >>> SHR;
    conv    = scaled[WO-1:0];
    conv_up = 1'b0;
    conv_dn = 1'b0;
    if (scaled > CMAX) begin
      conv_up = 1'b1;
      if (ROOF) conv = CMAX[WO-1:0];
    end else if (scaled < CMIN) begin
      conv_dn = 1'b1;
      if (ROOF) conv = CMIN[WO-1:0];
    end

    sum = bus.in_sub ? {{2{acc_q[WO-1]}}, acc_q} - {{2{conv[WO-1]}}, conv}
                     : {{2{acc_q[WO-1]}}, acc_q} + {{2{conv[WO-1]}}, conv};
    step_up = sum > SMAX;
    step_dn = sum < SMIN;
    step    = sum[WO-1:0];
    if (step_up && ROOF) step = CMAX[WO-1:0];
    if (step_dn && ROOF) step = CMIN[WO-1:0];

    up_n = up_q | conv_up | step_up;
    dn_n = dn_q | conv_dn | step_dn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      out_data_q  <= '0;
      out_up_q    <= 1'b0;
      out_dn_q    <= 1'b0;
    end else if (clr) begin
      state       <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (bus.in_last) begin
              out_data_q  <= step;
              out_up_q    <= up_n;
              out_dn_q    <= dn_n;
              acc_q       <= '0;
              up_q        <= 1'b0;
              dn_q        <= 1'b0;
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              acc_q <= step;
              up_q  <= up_n;
              dn_q  <= dn_n;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef FIXEDPOINT_ACC_COUNT_EN
  logic [CNTW-1:0] cnt_q, out_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      out_cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (accept) begin
      if (bus.in_last) begin
        out_cnt_q <= cnt_q + CNTW'(1);
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  assign bus.out_cnt = out_cnt_q;
`else
  assign bus.out_cnt = '0;
`endif

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_upflow   = out_up_q;
  assign bus.out_downflow = out_dn_q;
endmodule

// File: tb/tb_seq_fixed_point_accumulator.sv
// Scoreboard bench: four accumulators with different ROOF/ROUND/WOF settings run the same stimulus in lockstep.
module tb_seq_fixed_point_accumulator;
  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_sub, in_last, out_ready;
  logic [15:0] in_data;

  always #5 clk = ~clk;

  seq_fixed_point_accumulator_if #(.WI(16), .WO(16), .CNTW(16)) if_a ();
  seq_fixed_point_accumulator_if #(.WI(16), .WO(16), .CNTW(16)) if_b ();
  seq_fixed_point_accumulator_if #(.WI(16), .WO(12), .CNTW(16)) if_c ();
  seq_fixed_point_accumulator_if #(.WI(16), .WO(12), .CNTW(16)) if_d ();

  seq_fixed_point_accumulator #(.WII(8), .WIF(8), .WOI(8), .WOF(8), .ROOF(1'b1), .ROUND(1'b1), .CNTW(16))
    dut_a (.clk(clk), .rst(rst), .clr(clr), .bus(if_a));
  seq_fixed_point_accumulator #(.WII(8), .WIF(8), .WOI(8), .WOF(8), .ROOF(1'b0), .ROUND(1'b0), .CNTW(16))
    dut_b (.clk(clk), .rst(rst), .clr(clr), .bus(if_b));
  seq_fixed_point_accumulator #(.WII(8), .WIF(8), .WOI(8), .WOF(4), .ROOF(1'b1), .ROUND(1'b1), .CNTW(16))
    dut_c (.clk(clk), .rst(rst), .clr(clr), .bus(if_c));
  seq_fixed_point_accumulator #(.WII(8), .WIF(8), .WOI(8), .WOF(4), .ROOF(1'b0), .ROUND(1'b0), .CNTW(16))
    dut_d (.clk(clk), .rst(rst), .clr(clr), .bus(if_d));

  assign {if_a.in_valid, if_a.in_data, if_a.in_sub, if_a.in_last, if_a.out_ready} = {in_valid, in_data, in_sub, in_last, out_ready};
  assign {if_b.in_valid, if_b.in_data, if_b.in_sub, if_b.in_last, if_b.out_ready} = {in_valid, in_data, in_sub, in_last, out_ready};
  assign {if_c.in_valid, if_c.in_data, if_c.in_sub, if_c.in_last, if_c.out_ready} = {in_valid, in_data, in_sub, in_last, out_ready};
  assign {if_d.in_valid, if_d.in_data, if_d.in_sub, if_d.in_last, if_d.out_ready} = {in_valid, in_data, in_sub, in_last, out_ready};

  logic [3:0]  ov, ir, oup, odn;
  logic [15:0] od[4];
  logic [15:0] oc[4];
  assign ov  = {if_d.out_valid, if_c.out_valid, if_b.out_valid, if_a.out_valid};
  assign ir  = {if_d.in_ready, if_c.in_ready, if_b.in_ready, if_a.in_ready};
  assign oup = {if_d.out_upflow, if_c.out_upflow, if_b.out_upflow, if_a.out_upflow};
  assign odn = {if_d.out_downflow, if_c.out_downflow, if_b.out_downflow, if_a.out_downflow};
  assign od[0] = if_a.out_data;
  assign od[1] = if_b.out_data;
  assign od[2] = {4'h0, if_c.out_data};
  assign od[3] = {4'h0, if_d.out_data};
  assign oc[0] = if_a.out_cnt;
  assign oc[1] = if_b.out_cnt;
  assign oc[2] = if_c.out_cnt;
  assign oc[3] = if_d.out_cnt;

  localparam logic [3:0] ROOF_V  = 4'b0101;
  localparam logic [3:0] ROUND_V = 4'b0101;
`ifdef FIXEDPOINT_ACC_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0][15:0] data;
    logic [3:0]       up;
    logic [3:0]       dn;
    logic [15:0]      cnt;
  } exp_t;

  exp_t   sbq[$];
  longint m_acc[4];
  bit     m_up[4], m_dn[4];
  int     m_cnt;
  bit     pending;
  int     n_tests = 0;
  int     n_fail  = 0;

  function automatic int wof_of(int i);
    return (i < 2) ? 8 : 4;
  endfunction

  function automatic longint fdiv(longint a, longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Brings an exact value into a wo-bit signed range by saturation or wrap.
  task automatic fit(input longint v, input int wo, input bit roof, output longint r, output bit up, output bit dn);
    longint hi, lo, span;
    span = longint'(1) << wo;
    hi   = (span / 2) - 1;
    lo   = -(span / 2);
    up   = v > hi;
    dn   = v < lo;
    r    = v;
    if (up || dn) begin
      if (roof) r = up ? hi : lo;
      else begin
        r = v & (span - 1);
        if (r > hi) r = r - span;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0;
      m_up[i]  = 1'b0;
      m_dn[i]  = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic model_accept(input logic [15:0] d, input bit sub, input bit last);
    exp_t   e;
    longint x, c, s, r, sh;
    bit     cu, cd, su, sd;
    int     wof;
    e     = '0;
    m_cnt = (m_cnt + 1) % 65536;
    for (int i = 0; i < 4; i++) begin
      wof = wof_of(i);
      x   = longint'($signed(d));
      if (wof >= 8) x = x * (longint'(1) << (wof - 8));
      else begin
        sh = longint'(1) << (8 - wof);
        x  = ROUND_V[i] ? fdiv(x + sh / 2, sh) : fdiv(x, sh);
      end
      fit(x, 8 + wof, ROOF_V[i], c, cu, cd);
      s = sub ? m_acc[i] - c : m_acc[i] + c;
      fit(s, 8 + wof, ROOF_V[i], r, su, sd);
      m_acc[i]  = r;
      m_up[i]   = m_up[i] | cu | su;
      m_dn[i]   = m_dn[i] | cd | sd;
      e.data[i] = 16'(r & ((longint'(1) << (8 + wof)) - 1));
      e.up[i]   = m_up[i];
      e.dn[i]   = m_dn[i];
    end
    if (last) begin
      e.cnt = CNT_EN ? 16'(m_cnt) : 16'd0;
      sbq.push_back(e);
      model_clear();
      pending = 1'b1;
    end
  endtask

  task automatic cycle(input bit v, input logic [15:0] d, input bit sub, input bit last, input bit ordy, input bit c);
    in_valid  = v;
    in_data   = d;
    in_sub    = sub;
    in_last   = last;
    out_ready = ordy;
    clr       = c;
    check("in_ready", ir, {4{!pending}});
    check("out_valid", ov, {4{pending}});
    if (c) begin
      if (pending) void'(sbq.pop_front());
      model_clear();
      pending = 1'b0;
    end else if (pending) begin
      if (ordy) pending = 1'b0;
    end else if (v) begin
      model_accept(d, sub, last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (pending) void'(sbq.pop_front());
    pending = 1'b0;
    model_clear();
    check("rst_out_valid", ov, 4'h0);
    check("rst_in_ready", ir, 4'hF);
    check("rst_flags", {oup, odn}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_out_data%0d", i), od[i], 16'h0);
      check($sformatf("rst_out_cnt%0d", i), oc[i], 16'h0);
    end
  endtask

  // Monitor: compares whatever result is on display; pops on the handshake edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && clr === 1'b0 && ov[0] === 1'b1) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: out_valid=1 with no expected result at %0t", $time);
      end else begin
        for (int i = 0; i < 4; i++) begin
          check($sformatf("out_data%0d", i), od[i], sbq[0].data[i]);
          check($sformatf("out_upflow%0d", i), oup[i], sbq[0].up[i]);
          check($sformatf("out_downflow%0d", i), odn[i], sbq[0].dn[i]);
          check($sformatf("out_cnt%0d", i), oc[i], sbq[0].cnt);
        end
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    pending = 1'b0;
    model_clear();
    do_reset();

    cycle(1, 16'h0180, 0, 0, 1, 0);
    cycle(1, 16'h0240, 0, 0, 1, 0);
    cycle(1, 16'h0080, 1, 1, 1, 0);
    check("p1_data", od[0], 16'h0340);
    check("p1_flags", {oup[0], odn[0]}, 2'b00);
    check("p1_cnt", oc[0], CNT_EN ? 16'd3 : 16'd0);
    cycle(0, 16'h0, 0, 0, 1, 0);

    cycle(1, 16'h6400, 0, 0, 1, 0);
    cycle(1, 16'h6400, 0, 1, 1, 0);
    check("sat_data", od[0], 16'h7FFF);
    check("sat_up", oup[0], 1'b1);
    check("wrap_data", od[1], 16'hC800);
    check("wrap_up", oup[1], 1'b1);
    cycle(0, 16'h0, 0, 0, 1, 0);

    cycle(1, 16'h0018, 0, 1, 0, 0);
    check("round_data", od[2], 16'h0002);
    check("trunc_data", od[3], 16'h0001);
    for (int k = 0; k < 5; k++) cycle(1, 16'($urandom), 0, 1, 0, 0);
    cycle(1, 16'h1234, 0, 1, 1, 0);
    cycle(0, 16'h0, 0, 0, 1, 0);

    cycle(1, 16'h0300, 0, 0, 1, 0);
    cycle(1, 16'h0500, 1, 0, 1, 0);
    cycle(1, 16'h0700, 0, 1, 1, 1);
    cycle(1, 16'h0100, 0, 1, 0, 0);
    check("clr_data", od[0], 16'h0100);
    check("clr_cnt", oc[0], CNT_EN ? 16'd1 : 16'd0);
    do_reset();

    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 7))
        0: d = 16'h7FFF;
        1: d = 16'h8000;
        2: d = 16'h0008;
        3: d = 16'hFFF8;
        default: d = 16'($urandom);
      endcase
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
    end
    for (int k = 0; k < 10 && pending; k++) cycle(0, 16'h0, 0, 0, 1, 0);
    cycle(0, 16'h0, 0, 0, 1, 0);
    check("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
